writeback_stage: RTL and testbench
==================================

Name: writeback_stage

Overview:
- MEM/WB pipeline register and writeback driver of the 5-stage RV32I core.
- Captures memory-stage results and selects the final result: ALU, load data, or PC+4.
- Extracts and sign/zero-extends load data.
- Drives the decode-stage register-file write port: reg-write enable, rd address, result.
- Owns the data-memory read-response handshake and stalls the pipe while a load is outstanding.

Parameters:
DATA_WIDTH, 32, datapath width
ADDR_WIDTH, 5, register address width
PC_WIDTH, 10, PC width (PC+4 carried as PC_WIDTH+1 bits)
TIMEOUT_CYCLES, 16, load watchdog limit (used only with WB_LOAD_TIMEOUT_EN)

Ports:
i_clk  in  1  clock, rising edge
i_rst  in  1  synchronous reset, active-high
i_valid_m  in  1  M-stage holds a real instruction (0 = bubble)
i_regwrite_m  in  1  instruction writes rd
i_resultsrc_m  in  2  00 ALU, 01 load, 10 PC+4, 11 ALU
i_funct3_m  in  3  load size/sign
i_alu_result_m  in  DATA_WIDTH  ALU result / load address
i_pc4_m  in  PC_WIDTH+1  PC+4
i_rd_addr_m  in  ADDR_WIDTH  destination register
i_dmem_rvalid  in  1  read data valid this cycle
i_dmem_rdata  in  DATA_WIDTH  read data word
o_stall_m  out  1  hold IF/ID/EX/M (combinational)
o_reg_write_w  out  1  regfile write enable
o_rd_addr_w  out  ADDR_WIDTH  regfile write address
o_result_w  out  DATA_WIDTH  regfile write data
o_retire_w  out  1  one-cycle pulse per retired instruction
o_load_err  out  1  sticky load-timeout flag

Behaviour:
- Reset: synchronous, active-high. All outputs 0 on the first edge with i_rst=1; FSM to IDLE; watchdog counter 0; o_load_err cleared. Reset mid-wait abandons the load; a later stray rvalid in IDLE is ignored.
- A load is i_valid_m & i_resultsrc_m==01.
- FSM IDLE:
  - Non-load valid: registered into W next edge; latency 1 cycle.
  - Load with i_dmem_rvalid=1 same cycle: zero-wait, captured next edge.
  - Load with rvalid=0: o_stall_m=1; go to WAIT; W register loads a bubble (o_reg_write_w=0, o_retire_w=0).
- FSM WAIT:
  - o_stall_m=1 while rvalid=0. M inputs are held stable by upstream; block does not re-sample them.
  - On rvalid=1: o_stall_m=0 that cycle; data captured at the edge; return to IDLE.
- o_stall_m = load & ~i_dmem_rvalid in either state (combinational, no registered delay).
- Bubble (i_valid_m=0): W gets reg_write=0, retire=0. rd/result are don't-care but driven 0.
- o_reg_write_w = i_regwrite_m & (rd != 0). Writes to x0 are suppressed; instruction still retires.
- Result select: 00/11 → alu_result; 10 → zero-extended pc4; 01 → extracted load.
- Load extraction, addr = alu_result[1:0]:
  - LB 000: byte lane addr, sign-extend.
  - LBU 100: byte lane addr, zero-extend.
  - LH 001: half lane addr[1], sign-extend; addr[0] ignored.
  - LHU 101: half lane addr[1], zero-extend; addr[0] ignored.
  - LW 010 and all other codes: full word.
- Little-endian lanes: byte n = rdata[8n+7:8n].
- Outputs are registered; the decode regfile samples them on the following edge.

Optional Feature:
WB_LOAD_TIMEOUT_EN.
- Defined:
  - Counter increments each WAIT cycle with rvalid=0.
  - When it reaches TIMEOUT_CYCLES: set o_load_err (sticky until reset), retire the load with o_reg_write_w=0, o_retire_w=1, deassert stall, go to IDLE.
  - Counter clears on leaving WAIT.
- Undefined: no counter; WAIT persists indefinitely; o_load_err tied 0.

Test Plan:
- add x5 (alu=0x0000_0012, resultsrc=00, regwrite=1, rd=5) → next cycle reg_write=1, rd=5, result=0x12, retire=1; stall never high.
- LB, addr=0x...03, rdata=0x80FF_1234, rvalid same cycle → result=0xFFFF_FF80, no stall. Same with LBU → 0x0000_0080.
- LHU, addr=0x...02, rvalid 3 cycles late, rdata=0xBEEF_0000 → stall high exactly 3 cycles, bubbles in W, then result=0x0000_BEEF.
- jal rd=1, pc4=0x104 → result=0x0000_0104. Same with rd=0 → reg_write=0, retire=1.
- i_rst asserted in WAIT, then rvalid=1 → all outputs 0, IDLE, stall 0, no writeback.
- WB_LOAD_TIMEOUT_EN, TIMEOUT_CYCLES=16, rvalid never → stall high 16 cycles, then o_load_err=1, retire=1 with reg_write=0; next ALU op retires normally.

Source files
------------

// File: rtl/writeback_stage_if.sv
// MEM/WB boundary bundle for writeback_stage.
// Carries the M-stage instruction fields, the data-memory read response and
// the W-stage register-file write port. The slave modport is the writeback
// stage; the master modport is the surrounding pipeline/memory side.
interface writeback_stage_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int PC_WIDTH   = 10
);
    // M-stage instruction
    logic                  i_valid_m;
    logic                  i_regwrite_m;
    logic [1:0]            i_resultsrc_m;
    logic [2:0]            i_funct3_m;
    logic [DATA_WIDTH-1:0] i_alu_result_m;
    logic [PC_WIDTH:0]     i_pc4_m;
    logic [ADDR_WIDTH-1:0] i_rd_addr_m;
    // Data-memory read response
    logic                  i_dmem_rvalid;
    logic [DATA_WIDTH-1:0] i_dmem_rdata;
    // Pipeline hold and register-file write port
    logic                  o_stall_m;
    logic                  o_reg_write_w;
    logic [ADDR_WIDTH-1:0] o_rd_addr_w;
    logic [DATA_WIDTH-1:0] o_result_w;
    logic                  o_retire_w;
    logic                  o_load_err;

    modport slave (
        input  i_valid_m, i_regwrite_m, i_resultsrc_m, i_funct3_m,
               i_alu_result_m, i_pc4_m, i_rd_addr_m,
               i_dmem_rvalid, i_dmem_rdata,
        output o_stall_m, o_reg_write_w, o_rd_addr_w, o_result_w,
               o_retire_w, o_load_err
    );

    modport master (
        output i_valid_m, i_regwrite_m, i_resultsrc_m, i_funct3_m,
               i_alu_result_m, i_pc4_m, i_rd_addr_m,
               i_dmem_rvalid, i_dmem_rdata,
        input  o_stall_m, o_reg_write_w, o_rd_addr_w, o_result_w,
               o_retire_w, o_load_err
    );
endinterface

// File: rtl/writeback_stage.sv
// MEM/WB pipeline register and register-file write driver.
// Selects ALU / load / PC+4 result, extracts and extends load data, and
// stalls the pipe while a load waits for its read response.
// Handshake: a load is accepted when i_dmem_rvalid is high in the cycle the
// load sits in M; until then o_stall_m holds M stable and W receives bubbles.
// Optional load watchdog: define WB_LOAD_TIMEOUT_EN.
module writeback_stage #(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 5,
    parameter int PC_WIDTH       = 10,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic              i_clk,
    input  logic              i_rst,
    writeback_stage_if.slave  wb,
    output logic              o_dbg_state   // 0 = IDLE, 1 = WAIT
);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_WAIT = 1'b1
    } state_e;

    state_e                state_q, state_d;
    logic                  reg_write_q, reg_write_d;
    logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
    logic [DATA_WIDTH-1:0] result_q, result_d;
    logic                  retire_q, retire_d;
    logic                  is_load;
    logic                  stall;
    logic                  timeout;
    logic [DATA_WIDTH-1:0] load_data;

`ifdef WB_LOAD_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] cnt_inc;
    logic             load_err_q, load_err_d;
`else
    logic unused_timeout_cycles;
    assign unused_timeout_cycles = (TIMEOUT_CYCLES != 0);
`endif

    // Little-endian lane extraction with sign/zero extension by funct3
    function automatic logic [DATA_WIDTH-1:0] extract_load(
        input logic [2:0]            f3,
        input logic [1:0]            addr,
        input logic [DATA_WIDTH-1:0] rdata
    );
        logic [7:0]  b;
        logic [15:0] h;
        b = rdata[8*addr +: 8];
        h = rdata[16*addr[1] +: 16];
        case (f3)
            3'b000:  extract_load = {{(DATA_WIDTH-8){b[7]}}, b};
            3'b100:  extract_load = {{(DATA_WIDTH-8){1'b0}}, b};
            3'b001:  extract_load = {{(DATA_WIDTH-16){h[15]}}, h};
            3'b101:  extract_load = {{(DATA_WIDTH-16){1'b0}}, h};
            default: extract_load = rdata;
        endcase
    endfunction

    // Next-state, stall, watchdog and W-register next values
    always_comb begin
        state_d     = state_q;
        reg_write_d = 1'b0;
        rd_addr_d   = '0;
        result_d    = '0;
        retire_d    = 1'b0;
        timeout     = 1'b0;
        is_load     = wb.i_valid_m & (wb.i_resultsrc_m == 2'b01);
        load_data   = extract_load(wb.i_funct3_m, wb.i_alu_result_m[1:0], wb.i_dmem_rdata);

`ifdef WB_LOAD_TIMEOUT_EN
        cnt_inc = cnt_q + 1'b1;
        cnt_d   = '0;
        if (state_q == S_WAIT && is_load && !wb.i_dmem_rvalid) begin
            timeout = (cnt_inc == CNT_W'(TIMEOUT_CYCLES));
            cnt_d   = timeout ? '0 : cnt_inc;
        end
        load_err_d = load_err_q | timeout;
`endif

        stall = is_load & ~wb.i_dmem_rvalid & ~timeout & ~i_rst;

        case (state_q)
            S_IDLE:  if (stall) state_d = S_WAIT;
            S_WAIT:  if (!stall) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        if (timeout) begin
            // Abandoned load still retires, but never writes the regfile
            retire_d = 1'b1;
        end else if (wb.i_valid_m && !stall) begin
            retire_d    = 1'b1;
            reg_write_d = wb.i_regwrite_m & (|wb.i_rd_addr_m);
            rd_addr_d   = wb.i_rd_addr_m;
            case (wb.i_resultsrc_m)
                2'b01:   result_d = load_data;
                2'b10:   result_d = {{(DATA_WIDTH-PC_WIDTH-1){1'b0}}, wb.i_pc4_m};
                default: result_d = wb.i_alu_result_m;
            endcase
        end
    end

    // State and W pipeline registers with synchronous reset
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q     <= S_IDLE;
            reg_write_q <= 1'b0;
            rd_addr_q   <= '0;
            result_q    <= '0;
            retire_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            reg_write_q <= reg_write_d;
            rd_addr_q   <= rd_addr_d;
            result_q    <= result_d;
            retire_q    <= retire_d;
        end
    end

`ifdef WB_LOAD_TIMEOUT_EN
    // Watchdog counter and sticky timeout flag
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            cnt_q      <= '0;
            load_err_q <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            load_err_q <= load_err_d;
        end
    end
    assign wb.o_load_err = load_err_q;
`else
    assign wb.o_load_err = 1'b0;
`endif

    assign wb.o_stall_m     = stall;
    assign wb.o_reg_write_w = reg_write_q;
    assign wb.o_rd_addr_w   = rd_addr_q;
    assign wb.o_result_w    = result_q;
    assign wb.o_retire_w    = retire_q;
    assign o_dbg_state      = state_q;

endmodule

// File: tb/tb_writeback_stage.sv
// Self-checking bench for writeback_stage: vector table for single-cycle
// results, hand sequences for late load, reset in WAIT and the watchdog.
module tb_writeback_stage;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int PW = 10;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  logic dbg_state;
  always #5 clk = ~clk;

  writeback_stage_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .PC_WIDTH(PW)) wb();

  writeback_stage #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .PC_WIDTH(PW), .TIMEOUT_CYCLES(16)
  ) dut (
    .i_clk(clk),
    .i_rst(rst),
    .wb(wb),
    .o_dbg_state(dbg_state)
  );

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_bad = 0;
  logic [38:0] exp_q[$];

  function automatic logic [38:0] w_out(input logic ret, input logic rw,
                                        input logic [4:0] rd, input logic [31:0] res);
    return {ret, rw, rd, res};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic set_m(input logic valid, input logic regwrite, input logic [1:0] src,
                       input logic [2:0] f3, input logic [31:0] alu, input logic [10:0] pc4,
                       input logic [4:0] rd, input logic rvalid, input logic [31:0] rdata);
    wb.i_valid_m      = valid;
    wb.i_regwrite_m   = regwrite;
    wb.i_resultsrc_m  = src;
    wb.i_funct3_m     = f3;
    wb.i_alu_result_m = alu;
    wb.i_pc4_m        = pc4;
    wb.i_rd_addr_m    = rd;
    wb.i_dmem_rvalid  = rvalid;
    wb.i_dmem_rdata   = rdata;
  endtask

  // One cycle: check combinational stall, push expected W, clock, pop and compare
  task automatic step(input string name, input logic exp_stall, input logic [38:0] exp_w);
    logic [38:0] got;
    logic [38:0] exp;
    #1;
    check({name, " stall"}, 64'(wb.o_stall_m), 64'(exp_stall));
    exp_q.push_back(exp_w);
    @(posedge clk);
    #1;
    got = {wb.o_retire_w, wb.o_reg_write_w, wb.o_rd_addr_w, wb.o_result_w};
    exp = exp_q.pop_front();
    check({name, " wout"}, 64'(got), 64'(exp));
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic        valid;
    logic        regwrite;
    logic [1:0]  src;
    logic [2:0]  f3;
    logic [31:0] alu;
    logic [10:0] pc4;
    logic [4:0]  rd;
    logic [31:0] rdata;
    logic        e_ret;
    logic        e_rw;
    logic [4:0]  e_rd;
    logic [31:0] e_res;
  } vec_t;

  vec_t tbl[15];

  initial begin
    // add x5
    tbl[0]  = '{1, 1, 2'b00, 3'b000, 32'h0000_0012, 11'h000, 5'd5,  32'h1111_1111, 1, 1, 5'd5,  32'h0000_0012};
    // LB / LBU byte lane 3
    tbl[1]  = '{1, 1, 2'b01, 3'b000, 32'h0000_1003, 11'h000, 5'd6,  32'h80FF_1234, 1, 1, 5'd6,  32'hFFFF_FF80};
    tbl[2]  = '{1, 1, 2'b01, 3'b100, 32'h0000_1003, 11'h000, 5'd6,  32'h80FF_1234, 1, 1, 5'd6,  32'h0000_0080};
    // jal rd=1 and rd=0
    tbl[3]  = '{1, 1, 2'b10, 3'b000, 32'h0000_0200, 11'h104, 5'd1,  32'h0,         1, 1, 5'd1,  32'h0000_0104};
    tbl[4]  = '{1, 1, 2'b10, 3'b000, 32'h0000_0200, 11'h104, 5'd0,  32'h0,         1, 0, 5'd0,  32'h0000_0104};
    // LH upper half, addr[0] ignored
    tbl[5]  = '{1, 1, 2'b01, 3'b001, 32'h0000_0002, 11'h000, 5'd7,  32'h8001_7FFF, 1, 1, 5'd7,  32'hFFFF_8001};
    tbl[6]  = '{1, 1, 2'b01, 3'b001, 32'h0000_0003, 11'h000, 5'd7,  32'h8001_7FFF, 1, 1, 5'd7,  32'hFFFF_8001};
    // LHU lower half
    tbl[7]  = '{1, 1, 2'b01, 3'b101, 32'h0000_0000, 11'h000, 5'd8,  32'h1234_F00D, 1, 1, 5'd8,  32'h0000_F00D};
    // LW and an undefined funct3 -> full word
    tbl[8]  = '{1, 1, 2'b01, 3'b010, 32'h0000_0000, 11'h000, 5'd9,  32'hDEAD_BEEF, 1, 1, 5'd9,  32'hDEAD_BEEF};
    tbl[9]  = '{1, 1, 2'b01, 3'b011, 32'h0000_0001, 11'h000, 5'd10, 32'hCAFE_F00D, 1, 1, 5'd10, 32'hCAFE_F00D};
    // LB positive byte lane 1
    tbl[10] = '{1, 1, 2'b01, 3'b000, 32'h0000_0001, 11'h000, 5'd11, 32'h0000_7F00, 1, 1, 5'd11, 32'h0000_007F};
    // resultsrc 11 selects ALU
    tbl[11] = '{1, 1, 2'b11, 3'b000, 32'hA5A5_0000, 11'h3FC, 5'd31, 32'h0,         1, 1, 5'd31, 32'hA5A5_0000};
    // bubble
    tbl[12] = '{0, 1, 2'b00, 3'b000, 32'h1234_5678, 11'h010, 5'd7,  32'h0,         0, 0, 5'd0,  32'h0000_0000};
    // regwrite=0 still retires
    tbl[13] = '{1, 0, 2'b00, 3'b000, 32'h0000_0099, 11'h000, 5'd9,  32'h0,         1, 0, 5'd9,  32'h0000_0099};
    // LBU byte lane 2
    tbl[14] = '{1, 1, 2'b01, 3'b100, 32'h0000_0002, 11'h000, 5'd12, 32'h00AB_0000, 1, 1, 5'd12, 32'h0000_00AB};
  end

  // ---------------- test sequence ----------------
  initial begin
    rst = 1'b1;
    set_m(0, 0, 2'b00, 3'b000, 32'h0, 11'h0, 5'd0, 1'b0, 32'h0);
    @(posedge clk);
    @(posedge clk);
    #1;
    check("reset wout", 64'({wb.o_retire_w, wb.o_reg_write_w, wb.o_rd_addr_w, wb.o_result_w}), 64'h0);
    check("reset stall", 64'(wb.o_stall_m), 64'h0);
    check("reset err", 64'(wb.o_load_err), 64'h0);
    check("reset state", 64'(dbg_state), 64'h0);
    rst = 1'b0;

    // Table: rvalid always 1 (stray for non-loads, zero-wait for loads)
    for (int i = 0; i < 15; i++) begin
      set_m(tbl[i].valid, tbl[i].regwrite, tbl[i].src, tbl[i].f3, tbl[i].alu,
            tbl[i].pc4, tbl[i].rd, 1'b1, tbl[i].rdata);
      step($sformatf("vec%0d", i), 1'b0, w_out(tbl[i].e_ret, tbl[i].e_rw, tbl[i].e_rd, tbl[i].e_res));
    end

    // LHU with response 3 cycles late
    for (int i = 0; i < 3; i++) begin
      set_m(1, 1, 2'b01, 3'b101, 32'h0000_0402, 11'h0, 5'd13, 1'b0, 32'h0);
      step($sformatf("late_wait%0d", i), 1'b1, w_out(0, 0, 5'd0, 32'h0));
      check("late state", 64'(dbg_state), 64'h1);
    end
    set_m(1, 1, 2'b01, 3'b101, 32'h0000_0402, 11'h0, 5'd13, 1'b1, 32'hBEEF_0000);
    step("late_done", 1'b0, w_out(1, 1, 5'd13, 32'h0000_BEEF));
    check("late idle", 64'(dbg_state), 64'h0);

    // Reset while waiting, then stray rvalid in IDLE
    set_m(1, 1, 2'b01, 3'b010, 32'h0000_0010, 11'h0, 5'd14, 1'b0, 32'h0);
    step("rstw_wait0", 1'b1, w_out(0, 0, 5'd0, 32'h0));
    step("rstw_wait1", 1'b1, w_out(0, 0, 5'd0, 32'h0));
    rst = 1'b1;
    wb.i_dmem_rvalid = 1'b1;
    wb.i_dmem_rdata  = 32'h7777_7777;
    step("rstw_rst", 1'b0, w_out(0, 0, 5'd0, 32'h0));
    check("rstw state", 64'(dbg_state), 64'h0);
    rst = 1'b0;
    set_m(0, 0, 2'b00, 3'b000, 32'h0, 11'h0, 5'd0, 1'b1, 32'h5555_5555);
    step("rstw_stray", 1'b0, w_out(0, 0, 5'd0, 32'h0));
    check("rstw state2", 64'(dbg_state), 64'h0);

`ifdef WB_LOAD_TIMEOUT_EN
    // Watchdog: no response ever
    for (int i = 0; i < 16; i++) begin
      set_m(1, 1, 2'b01, 3'b010, 32'h0000_0020, 11'h0, 5'd3, 1'b0, 32'h0);
      step($sformatf("to_wait%0d", i), 1'b1, w_out(0, 0, 5'd0, 32'h0));
    end
    step("to_fire", 1'b0, w_out(1, 0, 5'd0, 32'h0));
    check("to err", 64'(wb.o_load_err), 64'h1);
    check("to state", 64'(dbg_state), 64'h0);
    set_m(1, 1, 2'b00, 3'b000, 32'h0000_0055, 11'h0, 5'd4, 1'b0, 32'h0);
    step("to_after", 1'b0, w_out(1, 1, 5'd4, 32'h0000_0055));
    check("to err sticky", 64'(wb.o_load_err), 64'h1);
`else
    check("err tied", 64'(wb.o_load_err), 64'h0);
`endif

    // Randomised ALU ops through the scoreboard
    for (int i = 0; i < 20; i++) begin
      logic [31:0] a;
      logic [4:0]  r;
      logic        rw;
      a  = $urandom;
      r  = 5'($urandom_range(0, 31));
      rw = 1'($urandom_range(0, 1));
      set_m(1, rw, 2'b00, 3'b000, a, 11'h0, r, 1'($urandom_range(0, 1)), $urandom);
      step($sformatf("rnd%0d", i), 1'b0, w_out(1, rw & (r != 5'd0), r, a));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
